// File: rtl/pipeline_ctrl.sv
// Pipeline advance controller for the 5-stage LC-3b pipe: turns hazard requests and
// memory handshakes into per-stage load enables, NOP selects and a stall-cycle count.
module pipeline_ctrl #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 gen_bubble,
  input  logic                 squash_ID,
  input  logic                 imem_resp,
  input  logic [1:0]           mem_op,
  input  logic                 mem_is_write,
  input  logic                 dmem_resp,
  output logic                 pc_load,
  output logic                 if_id_load,
  output logic                 id_ex_load,
  output logic                 ex_mem_load,
  output logic                 mem_wb_load,
  output logic                 if_id_sel_nop,
  output logic                 id_ex_sel_nop,
  output logic                 ifbuf_load,
  output logic                 ifbuf_sel,
  output logic                 imem_read,
  output logic                 dmem_read,
  output logic                 dmem_write,
  output logic                 indirect_phase,
  output logic [CNT_WIDTH-1:0] stall_cycles
);

  // Memory handshakes are request-held-until-response: a request stays asserted
  // until the single-cycle resp pulse; the pulse completes that access.
  typedef enum logic {MS_FIRST, MS_SECOND} mem_state_t;

  mem_state_t mem_state;
  logic       fetch_done;
  logic       mem_stall;
  logic       fetch_ok;

  always_comb begin
    pc_load        = 1'b0;
    if_id_load     = 1'b0;
    id_ex_load     = 1'b0;
    ex_mem_load    = 1'b0;
    mem_wb_load    = 1'b0;
    if_id_sel_nop  = 1'b0;
    id_ex_sel_nop  = 1'b0;
    ifbuf_load     = 1'b0;
    ifbuf_sel      = 1'b0;
    imem_read      = 1'b0;
    dmem_read      = 1'b0;
    dmem_write     = 1'b0;
    indirect_phase = 1'b0;
    mem_stall      = 1'b0;
    fetch_ok       = 1'b0;
    if (!reset) begin
      fetch_ok  = imem_resp | fetch_done;
      imem_read = !fetch_done;
      ifbuf_sel = fetch_done;
      case (mem_state)
        MS_FIRST: begin
          if (mem_op == 2'b01) begin
            dmem_write = mem_is_write;
            dmem_read  = !mem_is_write;
            mem_stall  = !dmem_resp;
          end else if (mem_op == 2'b10) begin
            // Pointer fetch never releases the pipe; the final access still follows.
            dmem_read = 1'b1;
            mem_stall = 1'b1;
          end
        end
        MS_SECOND: begin
          indirect_phase = 1'b1;
          dmem_write     = mem_is_write;
          dmem_read      = !mem_is_write;
          mem_stall      = !dmem_resp;
        end
        default: ;
      endcase

      if (mem_stall) begin
        pc_load = 1'b0;
      end else if (squash_ID) begin
        id_ex_sel_nop = 1'b1;
        id_ex_load    = 1'b1;
        ex_mem_load   = 1'b1;
        mem_wb_load   = 1'b1;
        if_id_load    = 1'b1;
        pc_load       = fetch_ok;
        if_id_sel_nop = !fetch_ok;
      end else if (gen_bubble) begin
        id_ex_sel_nop = 1'b1;
        id_ex_load    = 1'b1;
        ex_mem_load   = 1'b1;
        mem_wb_load   = 1'b1;
      end else if (!fetch_ok) begin
        if_id_load    = 1'b1;
        if_id_sel_nop = 1'b1;
        id_ex_load    = 1'b1;
        ex_mem_load   = 1'b1;
        mem_wb_load   = 1'b1;
      end else begin
        pc_load     = 1'b1;
        if_id_load  = 1'b1;
        id_ex_load  = 1'b1;
        ex_mem_load = 1'b1;
        mem_wb_load = 1'b1;
      end

      // Park a fetched word that IF/ID cannot take this cycle.
      ifbuf_load = imem_resp & !fetch_done & !if_id_load;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_state    <= MS_FIRST;
      fetch_done   <= 1'b0;
      stall_cycles <= '0;
    end else begin
      case (mem_state)
        MS_FIRST:  if (mem_op == 2'b10 && dmem_resp) mem_state <= MS_SECOND;
        MS_SECOND: if (dmem_resp) mem_state <= MS_FIRST;
        default:   mem_state <= MS_FIRST;
      endcase
      if (pc_load)
        fetch_done <= 1'b0;
      else if (ifbuf_load)
        fetch_done <= 1'b1;
      if (!pc_load && stall_cycles != '1)
        stall_cycles <= stall_cycles + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed scenarios plus random traffic compared against
// a transaction-level model; a 4-bit-counter instance shares the stimulus.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        gen_bubble = 1'b0;
  logic        squash_ID = 1'b0;
  logic        imem_resp = 1'b0;
  logic [1:0]  mem_op = 2'b00;
  logic        mem_is_write = 1'b0;
  logic        dmem_resp = 1'b0;

  logic [12:0] ctl_a, ctl_b;
  logic [15:0] cnt16;
  logic [3:0]  cnt4;

  logic [12:0] exp_q[$];
  int          n_vec = 0;
  int          n_bad = 0;

  // Model state: responses seen for the current indirect op, buffered fetch, counters.
  int          m_resp_seen = 0;
  bit          m_have_fetch = 1'b0;
  int          m_cnt16 = 0;
  int          m_cnt4 = 0;

  pipeline_ctrl dut (
    .clk(clk), .reset(reset), .gen_bubble(gen_bubble), .squash_ID(squash_ID),
    .imem_resp(imem_resp), .mem_op(mem_op), .mem_is_write(mem_is_write),
    .dmem_resp(dmem_resp),
    .pc_load(ctl_a[12]), .if_id_load(ctl_a[11]), .id_ex_load(ctl_a[10]),
    .ex_mem_load(ctl_a[9]), .mem_wb_load(ctl_a[8]), .if_id_sel_nop(ctl_a[7]),
    .id_ex_sel_nop(ctl_a[6]), .ifbuf_load(ctl_a[5]), .ifbuf_sel(ctl_a[4]),
    .imem_read(ctl_a[3]), .dmem_read(ctl_a[2]), .dmem_write(ctl_a[1]),
    .indirect_phase(ctl_a[0]), .stall_cycles(cnt16)
  );

  pipeline_ctrl #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .gen_bubble(gen_bubble), .squash_ID(squash_ID),
    .imem_resp(imem_resp), .mem_op(mem_op), .mem_is_write(mem_is_write),
    .dmem_resp(dmem_resp),
    .pc_load(ctl_b[12]), .if_id_load(ctl_b[11]), .id_ex_load(ctl_b[10]),
    .ex_mem_load(ctl_b[9]), .mem_wb_load(ctl_b[8]), .if_id_sel_nop(ctl_b[7]),
    .id_ex_sel_nop(ctl_b[6]), .ifbuf_load(ctl_b[5]), .ifbuf_sel(ctl_b[4]),
    .imem_read(ctl_b[3]), .dmem_read(ctl_b[2]), .dmem_write(ctl_b[1]),
    .indirect_phase(ctl_b[0]), .stall_cycles(cnt4)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s obs=%0h exp=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Called just after a rising edge; returns just after the next one.
  task automatic do_reset(input int cycles);
    reset = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      gen_bubble   = 1'($urandom_range(0, 1));
      squash_ID    = 1'($urandom_range(0, 1));
      imem_resp    = 1'($urandom_range(0, 1));
      mem_op       = 2'($urandom_range(0, 3));
      mem_is_write = 1'($urandom_range(0, 1));
      dmem_resp    = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("rst_ctl", 32'(ctl_a), 32'h0);
      check("rst_ctl4", 32'(ctl_b), 32'h0);
      check("rst_cnt16", 32'(cnt16), 32'h0);
      check("rst_cnt4", 32'(cnt4), 32'h0);
      @(posedge clk); #1;
    end
    reset = 1'b0;
    m_resp_seen  = 0;
    m_have_fetch = 1'b0;
    m_cnt16      = 0;
    m_cnt4       = 0;
  endtask

  // Driver + reference model for one cycle.
  task automatic apply(input logic gb, input logic sq, input logic ir,
                       input logic [1:0] op, input logic wr, input logic dr);
    bit in_final, is_final, req, stall, ok;
    bit pcl, ifl, dnl, ifnop, exnop, bufl;
    logic [12:0] exp_v;
    gen_bubble = gb; squash_ID = sq; imem_resp = ir;
    mem_op = op; mem_is_write = wr; dmem_resp = dr;

    in_final = (m_resp_seen == 1);
    is_final = in_final || (op == 2'd1);
    req      = in_final || (op == 2'd1) || (op == 2'd2);
    stall    = req && !(is_final && dr);
    ok       = ir || m_have_fetch;
    {pcl, ifl, dnl, ifnop, exnop} = '0;
    if (stall) begin
      pcl = 1'b0;
    end else if (sq) begin
      dnl = 1; exnop = 1; ifl = 1; pcl = ok; ifnop = !ok;
    end else if (gb) begin
      dnl = 1; exnop = 1;
    end else if (!ok) begin
      dnl = 1; ifl = 1; ifnop = 1;
    end else begin
      pcl = 1; ifl = 1; dnl = 1;
    end
    bufl = ir && !m_have_fetch && !ifl;
    exp_v = {pcl, ifl, dnl, dnl, dnl, ifnop, exnop, bufl, m_have_fetch, !m_have_fetch,
             req && !(is_final && wr), req && is_final && wr, in_final};
    exp_q.push_back(exp_v);

    @(negedge clk);
    check("cnt16", 32'(cnt16), 32'(m_cnt16));
    check("cnt4", 32'(cnt4), 32'(m_cnt4));
    check("ctl4", 32'(ctl_b), 32'(exp_v));
    check("ctl", 32'(ctl_a), 32'(exp_q.pop_front()));

    if (!pcl) begin
      if (m_cnt16 < 65535) m_cnt16++;
      if (m_cnt4 < 15) m_cnt4++;
    end
    if (pcl) m_have_fetch = 1'b0;
    else if (bufl) m_have_fetch = 1'b1;
    if (in_final && dr) m_resp_seen = 0;
    else if (!in_final && op == 2'd2 && dr) m_resp_seen = 1;
    @(posedge clk); #1;
  endtask

  initial begin
    @(posedge clk); #1;
    do_reset(3);

    // Normal streaming: every load high, no stalls.
    for (int i = 0; i < 4; i++) apply(0, 0, 1, 2'b00, 0, 0);
    check("t1_cnt", 32'(cnt16), 32'd0);

    // Indirect read, responses on cycles 2 and 5.
    for (int i = 0; i < 6; i++) apply(0, 0, 1, 2'b10, 0, (i == 2 || i == 5));
    check("t2_cnt", 32'(cnt16), 32'd5);

    // Single bubble, then recovery.
    apply(1, 0, 1, 2'b00, 0, 0);
    apply(0, 0, 1, 2'b00, 0, 0);

    // Squash wins over bubble.
    apply(1, 1, 1, 2'b00, 0, 0);

    // Fetch returns while a single data access is pending.
    apply(0, 0, 1, 2'b01, 0, 0);
    apply(0, 0, 0, 2'b01, 0, 0);
    apply(0, 0, 0, 2'b01, 0, 1);
    apply(0, 0, 0, 2'b00, 0, 0);
    apply(0, 0, 1, 2'b01, 1, 1);

    // Indirect store and squash with fetch missing.
    for (int i = 0; i < 4; i++) apply(0, (i == 3), (i == 0), 2'b10, 1, (i >= 1));
    apply(0, 1, 0, 2'b00, 0, 0);

    // Counter saturation: 2^4+3 stall cycles on the 4-bit instance.
    do_reset(1);
    for (int i = 0; i < 19; i++) apply(0, 0, 1, 2'b10, 0, 0);
    check("t6_sat4", 32'(cnt4), 32'hF);
    check("t6_cnt16", 32'(cnt16), 32'd19);

    // Reset in the middle of an indirect access.
    apply(0, 0, 1, 2'b10, 0, 1);
    do_reset(2);
    apply(0, 0, 1, 2'b00, 0, 0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0) do_reset(1);
      apply(1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 7) == 0),
            1'($urandom_range(0, 2) != 0), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Consumer of the hazard unit's gen_bubble/squash_ID requests: converts them into per-stage load enables and NOP-insert selects for the 5-stage LC-3b pipeline (IF, ID, EX, MEM, WB).
- Also sequences the MEM-stage data-memory handshake (single-access and two-access indirect LDI/STI) and the IF-stage fetch handshake, freezing the pipe while either memory is busy.
- Keeps a saturating count of cycles in which the PC did not advance.

Parameters:
CNT_WIDTH, 16, width of stall_cycles counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
gen_bubble  in  1  hold IF/ID and PC, inject NOP into ID/EX
squash_ID  in  1  discard instruction currently in ID (inject NOP into ID/EX)
imem_resp  in  1  instruction memory response, single-cycle pulse
mem_op  in  2  EX/MEM decode: 00 none, 01 single access, 10 indirect (2 accesses), 11 treated as 00
mem_is_write  in  1  final MEM access is a write (STB/STR/STI)
dmem_resp  in  1  data memory response, single-cycle pulse
pc_load  out  1  load PC
if_id_load  out  1  load IF/ID
id_ex_load  out  1  load ID/EX
ex_mem_load  out  1  load EX/MEM
mem_wb_load  out  1  load MEM/WB
if_id_sel_nop  out  1  IF/ID input mux selects 16'h0000
id_ex_sel_nop  out  1  ID/EX input mux selects NOP/control-zero
ifbuf_load  out  1  capture imem rdata into fetch buffer
ifbuf_sel  out  1  IF/ID takes fetch buffer instead of imem rdata
imem_read  out  1  instruction fetch request
dmem_read  out  1  data read request
dmem_write  out  1  data write request
indirect_phase  out  1  0 = pointer fetch / single access, 1 = final indirect access (MAR source select)
stall_cycles  out  CNT_WIDTH  saturating count of cycles with pc_load=0

Behaviour:
- State: MEM FSM {MS_FIRST, MS_SECOND}; fetch_done flag; stall_cycles counter. All are async-reset to MS_FIRST, 0, 0.
- While reset is high, every output is 0.
- All outputs are combinational from state and inputs. Zero-cycle latency.
- MEM FSM:
  - MS_FIRST, mem_op=01: assert dmem_write if mem_is_write, else dmem_read. Hold until dmem_resp. Stay in MS_FIRST.
  - MS_FIRST, mem_op=10: assert dmem_read, indirect_phase=0. On dmem_resp go to MS_SECOND.
  - MS_SECOND: indirect_phase=1; assert dmem_write if mem_is_write, else dmem_read. On dmem_resp return to MS_FIRST.
  - mem_op=00/11: no request. dmem_resp is ignored.
- mem_stall = (MS_FIRST & mem_op=01 & !dmem_resp) | (MS_FIRST & mem_op=10) | (MS_SECOND & !dmem_resp).
  - An indirect access therefore always stalls at least 1 cycle: the first response does not release the pipe.
- Fetch:
  - imem_read = !fetch_done.
  - fetch_ok = imem_resp | fetch_done.
  - ifbuf_sel = fetch_done.
  - ifbuf_load = imem_resp & !fetch_done & !if_id_load.
  - fetch_done sets on ifbuf_load and clears on any cycle with pc_load=1.
- Advance priority (first match wins):
  1. mem_stall: all loads 0, both sel_nop 0.
  2. squash_ID: id_ex_sel_nop=1; id_ex/ex_mem/mem_wb loads 1.
     - If fetch_ok: pc_load=1, if_id_load=1.
     - Else: pc_load=0, if_id_load=1, if_id_sel_nop=1.
     - gen_bubble is ignored when squash_ID is set, because the ID instruction is wrong-path.
  3. gen_bubble: pc_load=0, if_id_load=0, id_ex_sel_nop=1; id_ex/ex_mem/mem_wb loads 1.
  4. !fetch_ok: pc_load=0, if_id_load=1, if_id_sel_nop=1; downstream loads 1.
  5. Normal: all loads 1, no NOP selects.
- stall_cycles:
  - Increments each cycle with pc_load=0 and reset low.
  - Saturates at all-ones; no wrap.
- Reset mid-operation: a pending dmem/imem transaction is abandoned. The memory side must tolerate the dropped request.

Test Plan:
1. Reset high for 3 cycles, release; imem_resp=1 every cycle, mem_op=00 -> all loads 1 from the first post-reset cycle; stall_cycles stays 0.
2. mem_op=10, mem_is_write=0, dmem_resp pulses on cycles 2 and 5 -> dmem_read high cycles 0-5; indirect_phase 0 on cycles 0-2 and 1 on cycles 3-5; all loads 0 on cycles 0-4 and 1 on cycle 5; FSM returns to MS_FIRST; stall_cycles=5.
3. gen_bubble=1 for one cycle with normal fetch -> pc_load=0, if_id_load=0, id_ex_sel_nop=1, id_ex_load=1; next cycle all loads 1.
4. gen_bubble=1 and squash_ID=1 together, imem_resp=1 -> pc_load=1, if_id_load=1, id_ex_sel_nop=1 (squash wins).
5. imem_resp pulses while mem_op=01 with dmem_resp pending -> ifbuf_load=1, fetch_done set, imem_read drops. When dmem_resp arrives -> ifbuf_sel=1, pc_load=1, fetch_done clears next cycle.
6. Force 2^CNT_WIDTH+3 stall cycles with CNT_WIDTH=4 -> stall_cycles holds 4'hF.
